// File: rtl/conv3x3_stream.sv
// conv3x3_stream: streaming 3x3 convolution with two line buffers,
// run-time coefficients, shift normalisation and saturation.
module conv3x3_stream #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 4,
  parameter int IMG_W  = 4,
  parameter int IMG_H  = 4,
  parameter int SHIFT  = 4,
  parameter int ACC_W  = DATA_W + COEF_W + 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              coef_we,
  input  logic [3:0]        coef_idx,
  input  logic [COEF_W-1:0] coef_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [ACC_W-1:0] MAXV = ACC_W'((1 << DATA_W) - 1);

  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic [COEF_W-1:0] coef_q [9];
  logic [DATA_W-1:0] lb0_q [IMG_W];
  logic [DATA_W-1:0] lb1_q [IMG_W];
  logic [DATA_W-1:0] win_q [3][3];
  logic [DATA_W-1:0] tap [3][3];
  logic [ACC_W-1:0]  sum_d, res_d;
  logic [DATA_W-1:0] pix_d;
  logic              m_valid_q;
  logic [DATA_W-1:0] m_data_q;
  logic              m_last_q;
  logic              accept, fire, col_end, row_end;

  assign s_ready = !m_valid_q || m_ready;
  assign accept  = s_valid && s_ready;
  assign col_end = (col_q == CW'(IMG_W - 1));
  assign row_end = (row_q == RW'(IMG_H - 1));
  assign fire    = accept && (row_q >= RW'(2)) && (col_q >= CW'(2));
  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_last  = m_last_q;

  // Raster position of the next pixel to be accepted.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (col_end) begin
        col_d = '0;
        row_d = row_end ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  // Window including the incoming column; also its next-state value.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      tap[i][0] = win_q[i][1];
      tap[i][1] = win_q[i][2];
    end
    tap[0][2] = lb0_q[col_q];
    tap[1][2] = lb1_q[col_q];
    tap[2][2] = s_data;
  end

  // Weighted sum, normalising shift and saturation.
  always_comb begin
    sum_d = '0;
    for (int k = 0; k < 9; k++) begin
      sum_d = sum_d + ACC_W'(tap[k / 3][k % 3]) * ACC_W'(coef_q[k]);
    end
    res_d = sum_d >> SHIFT;
    pix_d = (res_d > MAXV) ? MAXV[DATA_W-1:0] : res_d[DATA_W-1:0];
  end

  // Position counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  // Coefficient bank; indices 9..15 fall through untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 9; k++) begin
        coef_q[k] <= COEF_W'((k == 4) ? 4 : ((k % 2 == 1) ? 2 : 1));
      end
    end else if (coef_we) begin
      for (int k = 0; k < 9; k++) begin
        if (coef_idx == 4'(k)) coef_q[k] <= coef_data;
      end
    end
  end

  // Line buffers and window; contents before fill are don't-care.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb0_q[col_q] <= lb1_q[col_q];
      lb1_q[col_q] <= s_data;
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          win_q[i][j] <= tap[i][j];
        end
      end
    end
  end

  // Single-entry output register with backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
    end else if (accept) begin
      m_valid_q <= fire;
      if (fire) begin
        m_data_q <= pix_d;
        m_last_q <= row_end && col_end;
      end
    end else if (m_ready) begin
      m_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv3x3_stream.sv
// tb_conv3x3_stream: directed frames with a queue scoreboard
// and an independent output monitor.
module tb_conv3x3_stream;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       coef_we = 1'b0;
  logic [3:0] coef_idx = '0;
  logic [3:0] coef_data = '0;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [7:0] s_data = '0;
  logic       m_valid;
  logic       m_ready = 1'b1;
  logic [7:0] m_data;
  logic       m_last;

  int n_vec = 0;
  int n_err = 0;
  logic [8:0] sb [$];

  always #5 clk = ~clk;

  conv3x3_stream dut (
    .clk(clk), .rst(rst),
    .coef_we(coef_we), .coef_idx(coef_idx), .coef_data(coef_data),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_last(m_last)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: every output transfer is checked against the queue head.
  always @(negedge clk) begin
    logic [8:0] e;
    if (!rst && m_valid && m_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("m_data", int'(m_data), int'(e[7:0]));
        chk("m_last", int'(m_last), int'(e[8]));
      end
    end
  end

  task automatic send(input int d, input bit f, input int e, input bit l);
    int t;
    s_valid = 1'b1;
    s_data = 8'(d);
    if (f) sb.push_back({l, 8'(e)});
    t = 0;
    @(negedge clk);
    while (!s_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!s_ready) chk("s_ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    if (f) chk("latency_m_valid", int'(m_valid), 1);
  endtask

  task automatic wr_coef(input int idx, input int val);
    coef_we = 1'b1;
    coef_idx = 4'(idx);
    coef_data = 4'(val);
    @(posedge clk);
    #1;
    coef_we = 1'b0;
  endtask

  // mode 0: constant val; mode 1: ramp 4r+c.
  task automatic frame(input int mode, input int val,
                       input int e0, input int e1,
                       input int e2, input int e3,
                       input int wr_at, input int wr_idx,
                       input int wr_val);
    int ex [4];
    int p, k;
    ex[0] = e0; ex[1] = e1; ex[2] = e2; ex[3] = e3;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        p = (mode == 1) ? 4 * r + c : val;
        k = (r >= 2 && c >= 2) ? (r - 2) * 2 + (c - 2) : 0;
        if (r * 4 + c == wr_at) begin
          coef_we = 1'b1;
          coef_idx = 4'(wr_idx);
          coef_data = 4'(wr_val);
        end
        send(p, r >= 2 && c >= 2, ex[k], r == 3 && c == 3);
        coef_we = 1'b0;
      end
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 20) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("drain_queue_empty", sb.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] held;
    #1;
    chk("rst_s_ready", int'(s_ready), 1);
    chk("rst_m_valid", int'(m_valid), 0);
    chk("rst_m_data", int'(m_data), 0);
    chk("rst_m_last", int'(m_last), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    frame(0, 16, 16, 16, 16, 16, -1, 0, 0);
    drain();

    wr_coef(9, 0);
    frame(1, 0, 5, 6, 9, 10, -1, 0, 0);
    frame(1, 0, 5, 6, 9, 10, -1, 0, 0);
    drain();

    for (int k = 0; k < 9; k++) wr_coef(k, 15);
    frame(0, 255, 255, 255, 255, 255, -1, 0, 0);
    drain();

    for (int k = 0; k < 9; k++) wr_coef(k, (k == 4) ? 1 : 0);
    frame(0, 160, 10, 10, 20, 20, 11, 4, 2);
    drain();

    do_reset();
    fork
      frame(1, 0, 5, 6, 9, 10, -1, 0, 0);
      begin
        int t;
        t = 0;
        @(posedge clk);
        #1;
        while (!m_valid && t < 40) begin
          @(posedge clk);
          #1;
          t++;
        end
        chk("bp_first_valid", int'(m_valid), 1);
        m_ready = 1'b0;
        held = m_data;
        repeat (5) begin
          @(negedge clk);
          chk("bp_s_ready_low", int'(s_ready), 0);
          chk("bp_m_valid_held", int'(m_valid), 1);
          chk("bp_m_data_stable", int'(m_data), int'(held));
        end
        @(posedge clk);
        #1;
        m_ready = 1'b1;
      end
    join
    drain();

    m_ready = 1'b0;
    for (int i = 0; i < 11; i++) begin
      send(i, i == 10, 10, 1'b0);
    end
    chk("pre_rst_pending", int'(m_valid), 1);
    rst = 1'b1;
    #1;
    chk("midrst_m_valid", int'(m_valid), 0);
    chk("midrst_s_ready", int'(s_ready), 1);
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_ready = 1'b1;
    frame(1, 0, 5, 6, 9, 10, -1, 0, 0);
    drain();

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
